// File: rtl/ndp_stream_loader.sv
// ndp_stream_loader
// Front-end loader for the NDP core. Assembles host BUS_WIDTH-bit words into
// one activation column (A_ROWS elements) and one weight row (B_COLS elements)
// per reduction step k, and presents each pair as a single wide vector beat.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, cfg_k    job start pulse (ignored while busy), number of k-steps
//   in_valid/ready  host word handshake, in_data host word
//   act_out/wgt_out assembled activation column / weight row
//   vec_valid/ready vector handshake toward the feeder, vec_last marks k = K-1
//   busy, done      job in progress, one-cycle job-complete pulse
//
// Optional feature macro: LOADER_OVERLAP_EN
//   When defined, a separate output register holds the emitted vector so that
//   loading of step k+1 overlaps the drain of step k.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | accepting activation words
// LOAD_B | accepting weight words
// EMIT   | vector presented, waiting for vec_ready (overlap: final vector only)
// FIN    | one-cycle done pulse
module ndp_stream_loader #(
    parameter int WIDTH     = 16,
    parameter int BUS_WIDTH = 32,
    parameter int A_ROWS    = 4,
    parameter int B_COLS    = 256,
    parameter int K_BITS    = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [K_BITS-1:0]         cfg_k,
    input  logic                      in_valid,
    input  logic [BUS_WIDTH-1:0]      in_data,
    output logic                      in_ready,
    output logic [A_ROWS*WIDTH-1:0]   act_out,
    output logic [B_COLS*WIDTH-1:0]   wgt_out,
    output logic                      vec_valid,
    input  logic                      vec_ready,
    output logic                      vec_last,
    output logic                      busy,
    output logic                      done
);

    localparam int A_WORDS   = A_ROWS * WIDTH / BUS_WIDTH;
    localparam int B_WORDS   = B_COLS * WIDTH / BUS_WIDTH;
    localparam int MAX_WORDS = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_WORDS - 1);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EMIT, S_FIN} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          wcnt_q, wcnt_d;
    logic [K_BITS-1:0]         k_q, k_d;
    logic [K_BITS-1:0]         k_tot_q, k_tot_d;
    logic [A_ROWS*WIDTH-1:0]   act_q, act_d;
    logic [B_COLS*WIDTH-1:0]   wgt_q, wgt_d;
    logic                      in_ready_q, in_ready_d;
    logic                      vec_valid_q, vec_valid_d;
    logic                      vec_last_q, vec_last_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      xfer;

`ifdef LOADER_OVERLAP_EN
    logic [A_ROWS*WIDTH-1:0]   act_o_q, act_o_d;
    logic [B_COLS*WIDTH-1:0]   wgt_o_q, wgt_o_d;

    // The last weight word may only complete the step when the output
    // register is free or draining in this same cycle.
    assign in_ready = in_ready_q &&
                      !(state_q == S_LOAD_B && wcnt_q == B_LAST && vec_valid_q && !vec_ready);
    assign act_out  = act_o_q;
    assign wgt_out  = wgt_o_q;
`else
    assign in_ready = in_ready_q;
    assign act_out  = act_q;
    assign wgt_out  = wgt_q;
`endif

    assign vec_valid = vec_valid_q;
    assign vec_last  = vec_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign xfer      = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        k_d         = k_q;
        k_tot_d     = k_tot_q;
        act_d       = act_q;
        wgt_d       = wgt_q;
        in_ready_d  = in_ready_q;
        vec_valid_d = vec_valid_q;
        vec_last_d  = vec_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef LOADER_OVERLAP_EN
        act_o_d     = act_o_q;
        wgt_o_d     = wgt_o_q;
        // Output register drains independently of the load states.
        if (vec_valid_q && vec_ready) begin
            vec_valid_d = 1'b0;
            vec_last_d  = 1'b0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    k_d    = '0;
                    wcnt_d = '0;
                    if (cfg_k != '0) begin
                        k_tot_d    = cfg_k;
                        in_ready_d = 1'b1;
                        state_d    = S_LOAD_A;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_LOAD_A: begin
                if (xfer) begin
                    act_d[BUS_WIDTH*wcnt_q +: BUS_WIDTH] = in_data;
                    if (wcnt_q == A_LAST) begin
                        wcnt_d  = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (xfer) begin
                    wgt_d[BUS_WIDTH*wcnt_q +: BUS_WIDTH] = in_data;
                    if (wcnt_q == B_LAST) begin
                        wcnt_d      = '0;
                        vec_valid_d = 1'b1;
                        vec_last_d  = (k_q == k_tot_q - K_BITS'(1));
`ifdef LOADER_OVERLAP_EN
                        act_o_d = act_q;
                        wgt_o_d = wgt_d;
                        if (k_q == k_tot_q - K_BITS'(1)) begin
                            in_ready_d = 1'b0;
                            state_d    = S_EMIT;
                        end else begin
                            k_d     = k_q + K_BITS'(1);
                            state_d = S_LOAD_A;
                        end
`else
                        in_ready_d = 1'b0;
                        state_d    = S_EMIT;
`endif
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            S_EMIT: begin
                if (vec_valid_q && vec_ready) begin
                    vec_valid_d = 1'b0;
                    vec_last_d  = 1'b0;
                    if (vec_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        k_d        = k_q + K_BITS'(1);
                        in_ready_d = 1'b1;
                        state_d    = S_LOAD_A;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            k_q         <= '0;
            k_tot_q     <= '0;
            act_q       <= '0;
            wgt_q       <= '0;
            in_ready_q  <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LOADER_OVERLAP_EN
            act_o_q     <= '0;
            wgt_o_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            k_q         <= k_d;
            k_tot_q     <= k_tot_d;
            act_q       <= act_d;
            wgt_q       <= wgt_d;
            in_ready_q  <= in_ready_d;
            vec_valid_q <= vec_valid_d;
            vec_last_q  <= vec_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef LOADER_OVERLAP_EN
            act_o_q     <= act_o_d;
            wgt_o_q     <= wgt_o_d;
`endif
        end
    end

endmodule

// File: tb/tb_ndp_stream_loader.sv
// Testbench for ndp_stream_loader at default parameters. Job-level vectors
// live in a table; cfg_k=0 and reset-abort are hand-written sequences.
// Host word w of a job (step s = w/130, i = w%130) carries:
//   A word i (i<2)  : {2i+2+s, 2i+1+s}  -> act element n = n+1+s
//   B word j (i-2)  : {2j+1+s, 2j+s}    -> wgt element n = n+s
module tb_ndp_stream_loader;

    localparam int WIDTH     = 16;
    localparam int BUS_WIDTH = 32;
    localparam int A_ROWS    = 4;
    localparam int B_COLS    = 256;
    localparam int K_BITS    = 12;
    localparam int A_WORDS   = 2;
    localparam int B_WORDS   = 128;
    localparam int STEP_W    = A_WORDS + B_WORDS;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [K_BITS-1:0]       cfg_k = '0;
    logic                    in_valid = 1'b0;
    logic [BUS_WIDTH-1:0]    in_data = '0;
    logic                    in_ready;
    logic [A_ROWS*WIDTH-1:0] act_out;
    logic [B_COLS*WIDTH-1:0] wgt_out;
    logic                    vec_valid;
    logic                    vec_ready = 1'b0;
    logic                    vec_last;
    logic                    busy;
    logic                    done;

    int n_tests = 0;
    int n_fail  = 0;

    ndp_stream_loader #(
        .WIDTH(WIDTH), .BUS_WIDTH(BUS_WIDTH), .A_ROWS(A_ROWS),
        .B_COLS(B_COLS), .K_BITS(K_BITS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .act_out(act_out), .wgt_out(wgt_out),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int idle_pct;
        int stall;
        bit spurious;
        int exp_words;
        int exp_beats;
    } job_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] gen_word(input int w);
        int s, i, j;
        s = w / STEP_W;
        i = w % STEP_W;
        if (i < A_WORDS)
            return {16'(2*i + 2 + s), 16'(2*i + 1 + s)};
        j = i - A_WORDS;
        return {16'(2*j + 1 + s), 16'(2*j + s)};
    endfunction

    function automatic logic [63:0] exp_act(input int s);
        logic [63:0] v;
        for (int n = 0; n < A_ROWS; n++) v[16*n +: 16] = 16'(n + 1 + s);
        return v;
    endfunction

    // Index of first weight element differing from the expected ramp, or -1.
    function automatic int wgt_bad(input logic [B_COLS*WIDTH-1:0] w, input int s);
        for (int n = 0; n < B_COLS; n++)
            if (w[16*n +: 16] !== 16'(n + s)) return n;
        return -1;
    endfunction

    task automatic run_job(input job_vec_t v);
        int  words, beats, last_beat_cyc, stall_left, bad;
        bit  finished, was_stalled;
        words = 0; beats = 0; last_beat_cyc = -10;
        stall_left = v.stall; finished = 0; was_stalled = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_k = K_BITS'(v.k);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            start     = v.spurious && (beats < v.k) && ($urandom_range(0, 9) == 0);
            cfg_k     = K_BITS'(5);
            in_valid  = (words < v.k * STEP_W) && ($urandom_range(0, 99) >= v.idle_pct);
            in_data   = in_valid ? gen_word(words) : $urandom();
            vec_ready = !(vec_valid && stall_left > 0);
            if (vec_valid && stall_left > 0) stall_left--;
            #1;
            if (was_stalled) check("vec_valid_held", 64'(vec_valid), 64'd1);
            if (vec_valid) begin
                bad = wgt_bad(wgt_out, beats);
                check("act_out", act_out, exp_act(beats));
                check("wgt_out_first_bad_elem", 64'(bad), 64'(-1));
                check("vec_last", 64'(vec_last), 64'(beats == v.k - 1));
                check("in_ready_in_emit", 64'(in_ready), 64'd0);
                if (beats == 0)
                    check("act_packing", act_out, 64'h0004_0003_0002_0001);
            end
            was_stalled = vec_valid && !vec_ready;
            if (in_valid && in_ready) words++;
            if (vec_valid && vec_ready) begin
                beats++;
                last_beat_cyc = cyc;
            end
            if (done) begin
                check("done_timing", 64'(cyc), 64'(last_beat_cyc + 1));
                check("busy_in_fin", 64'(busy), 64'd1);
                finished = 1;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!finished) check("job_timeout", 64'd0, 64'd1);
        check("words_accepted", 64'(words), 64'(v.exp_words));
        check("vector_beats", 64'(beats), 64'(v.exp_beats));
        @(negedge clk);
        #1;
        check("busy_after_job", 64'(busy), 64'd0);
        check("done_after_job", 64'(done), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_vec_valid"}, 64'(vec_valid), 64'd0);
        check({tag, "_vec_last"}, 64'(vec_last), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_act_out"}, act_out, 64'd0);
        check({tag, "_wgt_or"}, 64'(|wgt_out), 64'd0);
    endtask

    job_vec_t jobs[4];

    initial begin
        int words;
        bit saw_ready, saw_done;

        jobs[0] = '{k: 21, idle_pct: 0,  stall: 0,  spurious: 0, exp_words: 2730, exp_beats: 21};
        jobs[1] = '{k: 1,  idle_pct: 0,  stall: 10, spurious: 0, exp_words: 130,  exp_beats: 1};
        jobs[2] = '{k: 3,  idle_pct: 30, stall: 0,  spurious: 1, exp_words: 390,  exp_beats: 3};
        jobs[3] = '{k: 2,  idle_pct: 10, stall: 3,  spurious: 1, exp_words: 260,  exp_beats: 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int t = 0; t < 4; t++) run_job(jobs[t]);

        // cfg_k == 0: straight to FIN, no words accepted.
        @(negedge clk);
        start = 1'b1;
        cfg_k = '0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("k0_busy", 64'(busy), 64'd1);
        check("k0_done", 64'(done), 64'd1);
        saw_ready = in_ready;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            saw_ready |= in_ready;
        end
        check("k0_in_ready_never", 64'(saw_ready), 64'd0);
        check("k0_idle_busy", 64'(busy), 64'd0);
        check("k0_idle_done", 64'(done), 64'd0);
        in_valid = 1'b0;

        // Reset while LOAD_B word 50 is offered aborts without done.
        @(negedge clk);
        start = 1'b1;
        cfg_k = K_BITS'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        words = 0;
        vec_ready = 1'b1;
        for (int c = 0; c < 1000 && words < A_WORDS + 50; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = gen_word(words);
            #1;
            if (in_valid && in_ready) words++;
        end
        check("abort_reached_word50", 64'(words), 64'(A_WORDS + 50));
        @(negedge clk);
        in_data = gen_word(words);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        saw_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        run_job('{k: 1, idle_pct: 0, stall: 0, spurious: 0, exp_words: 130, exp_beats: 1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
